act_fetch_sched: RTL and testbench
==================================

ACT_FETCH_SCHED -- requirements
Module: act_fetch_sched

Interface
REQ-001 SHALL take parameters: NUM_REQ, default 4, number of PEC requesters.
REQ-002 SHALL take parameters: ADDR_W, default 12, activation global-buffer (GB) word address width.
REQ-003 SHALL take parameters: DATA_W, default 64, GB word width.
REQ-004 SHALL take parameters: LEN_W, default 5, burst-length field width.
REQ-005 SHALL take parameters: RD_LAT, default 2, fixed GB read latency in cycles (RD_LAT >= 1).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req_vld  input  NUM_REQ  per-requester fetch request, held until accepted.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  per-requester burst start address (slice i = requester i).
REQ-010 req_len  input  NUM_REQ*LEN_W  per-requester beat count minus 1 (value+1 is the real count).
REQ-011 req_acc  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-012 pause  input  1  freezes read issue while high.
REQ-013 gb_rd_en  output  1  GB read strobe.
REQ-014 gb_rd_addr  output  ADDR_W  GB read address.
REQ-015 gb_rd_data  input  DATA_W  GB read data, valid RD_LAT cycles after gb_rd_en.
REQ-016 rsp_vld  output  NUM_REQ  one-hot response valid, routed to the owning requester.
REQ-017 rsp_data  output  DATA_W  response data, equal to gb_rd_data.
REQ-018 rsp_last  output  1  marks the final beat of a burst.
REQ-019 busy  output  1  high while a burst is issuing or any read is in flight.

Function
REQ-020 FSM SHALL have exactly two states: IDLE and BURST.
REQ-021 IDLE: when |req_vld, SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ.
REQ-022 On grant SHALL pulse req_acc[g] for one cycle, latch addr/len/id of g, and enter BURST next cycle.
REQ-023 BURST: each cycle with pause=0 SHALL assert gb_rd_en with the current address, then increment address and beat count.
REQ-024 pause=1 SHALL hold gb_rd_en=0 and freeze address and beat count; in-flight responses SHALL still drain.
REQ-025 A burst SHALL issue exactly len+1 beats; len=0 gives a single beat.
REQ-026 After the last beat, SHALL return to IDLE; exactly one IDLE cycle separates consecutive bursts.
REQ-027 Address SHALL wrap modulo 2^ADDR_W (e.g. 0xFFF -> 0x000).
REQ-028 Response pipeline SHALL be a RD_LAT-deep shift of {valid, id, last}.
REQ-029 rsp_vld[id] and rsp_last SHALL appear exactly RD_LAT cycles after the corresponding gb_rd_en.
REQ-030 Responses SHALL keep issue order and are not back-pressurable.
REQ-031 Requests arriving in BURST SHALL wait; req_vld changes during BURST SHALL not affect the latched burst.
REQ-032 A requester deasserting req_vld before acceptance SHALL simply not be granted.
REQ-033 busy SHALL be (state==BURST) OR any valid bit set in the response pipeline.
REQ-034 With req_vld=0, SHALL not assert gb_rd_en, req_acc or rsp_vld.

Reset
REQ-035 On rst_n low, SHALL immediately clear: state=IDLE, all outputs 0, response pipeline cleared, round-robin pointer such that requester 0 has highest priority.
REQ-036 Reset mid-burst SHALL discard the burst and all in-flight responses; no rsp_vld after release until a new grant.

Structure
REQ-037 Shared package SHALL hold default parameter values and the state encoding (IDLE=0, BURST=1).
REQ-038 The round-robin arbiter SHALL be one sub-module, rr_arb (req, advance -> one-hot gnt, registered pointer).
REQ-039 The scheduler SHALL be synchronous single-clock, with no combinational path from gb_rd_data to control.

Verification
REQ-040 Single req 0, addr 0x010, len 3 -> req_acc[0] pulse; rd_en at addrs 0x010..0x013; rsp_vld[0] x4 at +2 cycles; rsp_last on 4th.
REQ-041 All 4 req_vld held, len 0 -> grants 0,1,2,3,0 in order, one IDLE gap between grants.
REQ-042 addr 0xFFE, len 2 -> rd addrs 0xFFE, 0xFFF, 0x000.
REQ-043 pause high for cycles 2-4 of an 8-beat burst -> rd_en gap of 3 cycles, addresses contiguous, earlier responses still delivered.
REQ-044 rst_n low mid-burst with 2 reads in flight -> all outputs 0, no rsp_vld after release; next grant goes to requester 0 when all request.

Source files
------------

// File: rtl/act_fetch_sched_pkg.sv
// Activation fetch scheduler: shared defaults and state encoding.
// Imported by the interface, arbiter and scheduler top.
package act_fetch_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_RD_LAT  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/act_fetch_sched_if.sv
// Requester, GB read port and response bundle of the fetch scheduler.
// slave is the scheduler side, master is the environment side.
interface act_fetch_sched_if
  import act_fetch_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
) ();

  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_acc;
  logic                      pause;
  logic                      gb_rd_en;
  logic [ADDR_W-1:0]         gb_rd_addr;
  logic [DATA_W-1:0]         gb_rd_data;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_last;
  logic                      busy;

  modport slave (
    input  req_vld,
    input  req_addr,
    input  req_len,
    input  pause,
    input  gb_rd_data,
    output req_acc,
    output gb_rd_en,
    output gb_rd_addr,
    output rsp_vld,
    output rsp_data,
    output rsp_last,
    output busy
  );

  modport master (
    output req_vld,
    output req_addr,
    output req_len,
    output pause,
    output gb_rd_data,
    input  req_acc,
    input  gb_rd_en,
    input  gb_rd_addr,
    input  rsp_vld,
    input  rsp_data,
    input  rsp_last,
    input  busy
  );

endinterface

// File: rtl/act_fetch_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from last winner + 1.
// Pointer resets to N-1 so requester 0 wins first.
module rr_arb
  import act_fetch_sched_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int IW = id_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] ptr;

  // Walk from farthest to nearest so the nearest asserted requester wins.
  always_comb begin
    logic [IW-1:0] idx;
    idx    = '0;
    gnt    = '0;
    gnt_id = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(N - 1);
    end else if (advance && |req) begin
      ptr <= gnt_id;
    end
  end

endmodule

// File: rtl/act_fetch_sched.sv
// Activation fetch scheduler: grants PEC burst requests round-robin,
// issues GB reads and routes fixed-latency responses to the owner.
module act_fetch_sched
  import act_fetch_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input logic              clk,
  input logic              rst_n,
  act_fetch_sched_if.slave bus
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int TOP  = RD_LAT - 1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    cnt;
  logic [ID_W-1:0]     id;
  logic [NUM_REQ-1:0]  acc;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                advance;
  logic                issue;
  logic                last_beat;

  logic [ADDR_W-1:0]   addr_a [NUM_REQ];
  logic [LEN_W-1:0]    len_a  [NUM_REQ];

  logic [RD_LAT-1:0]   p_vld;
  logic [RD_LAT-1:0]   p_last;
  logic [ID_W-1:0]     p_id [RD_LAT];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]  = bus.req_len[i*LEN_W +: LEN_W];
  end

  assign advance   = (state == IDLE) && (|bus.req_vld);
  assign issue     = (state == BURST) && !bus.pause;
  assign last_beat = (cnt == len);

  rr_arb #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_vld),
    .advance (advance),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      id    <= '0;
      acc   <= '0;
    end else begin
      acc <= '0;
      unique case (state)
        IDLE: begin
          if (advance) begin
            acc   <= gnt;
            addr  <= addr_a[gnt_id];
            len   <= len_a[gnt_id];
            id    <= gnt_id;
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            addr <= addr + 1'b1;
            cnt  <= cnt + 1'b1;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response tags ride alongside the GB read latency; no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld  <= '0;
      p_last <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        p_id[i] <= '0;
      end
    end else begin
      p_vld[0]  <= issue;
      p_last[0] <= issue && last_beat;
      p_id[0]   <= id;
      for (int i = 1; i < RD_LAT; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_last[i] <= p_last[i-1];
        p_id[i]   <= p_id[i-1];
      end
    end
  end

  assign bus.req_acc    = acc;
  assign bus.gb_rd_en   = issue;
  assign bus.gb_rd_addr = addr;

  assign bus.rsp_vld  = p_vld[TOP]
                      ? (NUM_REQ'(1) << p_id[TOP])
                      : '0;
  assign bus.rsp_last = p_vld[TOP] & p_last[TOP];
  assign bus.rsp_data = p_vld[TOP] ? bus.gb_rd_data : '0;
  assign bus.busy     = (state == BURST) | (|p_vld);

endmodule

// File: tb/tb_act_fetch_sched.sv
// Directed bench for act_fetch_sched: grants, bursts, wrap,
// pause, and reset behaviour against hand-computed timelines.
module tb_act_fetch_sched;
  import act_fetch_sched_pkg::*;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int LW = 5;
  localparam int RL = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  act_fetch_sched_if #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LEN_W   (LW)
  ) bus ();

  act_fetch_sched #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LEN_W   (LW),
    .RD_LAT  (RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {52'hDA7A000000000, a};
  endfunction

  // GB model with a two-cycle read latency
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] m1 = '0, m2 = '0;
  always @(posedge clk) begin
    v1 <= bus.gb_rd_en;
    m1 <= pat(bus.gb_rd_addr);
    v2 <= v1;
    m2 <= m1;
  end
  assign bus.gb_rd_data = v2 ? m2 : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct { int c; logic [AW-1:0] a; } rd_t;
  typedef struct { int c; logic [N-1:0] v; logic l; logic [DW-1:0] d; } rsp_t;
  typedef struct { int c; logic [N-1:0] v; } acc_t;

  rd_t  rdq[$];
  rsp_t rspq[$];
  acc_t accq[$];
  logic busy_log[int];

  always @(negedge clk) begin
    if (bus.gb_rd_en === 1'b1) rdq.push_back('{cyc, bus.gb_rd_addr});
    if (|bus.rsp_vld)
      rspq.push_back('{cyc, bus.rsp_vld, bus.rsp_last, bus.rsp_data});
    if (|bus.req_acc) accq.push_back('{cyc, bus.req_acc});
    busy_log[cyc] = bus.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rdq.delete();
    rspq.delete();
    accq.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [LW-1:0] l);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_len[i*LW +: LW]  = l;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (bus.req_acc !== '0 || bus.gb_rd_en !== 1'b0 ||
        bus.gb_rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_ctl: acc=%h en=%b addr=%h want 0/0/0",
               bus.req_acc, bus.gb_rd_en, bus.gb_rd_addr);
    end
    n_cmp++;
    if (bus.rsp_vld !== '0 || bus.rsp_last !== 1'b0 ||
        bus.rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset_rsp: vld=%h last=%b data=%h want 0",
               bus.rsp_vld, bus.rsp_last, bus.rsp_data);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    tick();
    rst_n = 1'b1;
    clr();
    repeat (6) tick();
    n_cmp++;
    if (rdq.size() != 0 || rspq.size() != 0 || accq.size() != 0) begin
      n_err++;
      $display("FAIL idle_quiet: rd=%0d rsp=%0d acc=%0d want 0/0/0",
               rdq.size(), rspq.size(), accq.size());
    end
  endtask

  task automatic test_rr();
    int c0;
    logic [N-1:0]  ev;
    logic [AW-1:0] ea;
    clr();
    for (int i = 0; i < N; i++) set_req(i, AW'(12'h100 + 16 * i), '0);
    bus.req_vld = 4'hF;
    c0 = cyc;
    repeat (9) tick();
    bus.req_vld = '0;
    repeat (6) tick();
    n_cmp++;
    if (accq.size() != 5) begin
      n_err++;
      $display("FAIL rr_acc_n: got %0d want 5", accq.size());
    end
    for (int k = 0; k < 5 && k < accq.size(); k++) begin
      ev = N'(1) << (k % N);
      n_cmp++;
      if (accq[k].c != c0 + 1 + 2 * k || accq[k].v !== ev) begin
        n_err++;
        $display("FAIL rr_acc[%0d]: cyc %0d val %h want cyc %0d val %h",
                 k, accq[k].c - c0, accq[k].v, 1 + 2 * k, ev);
      end
    end
    n_cmp++;
    if (rdq.size() != 5 || rspq.size() != 5) begin
      n_err++;
      $display("FAIL rr_rd_n: rd %0d rsp %0d want 5/5",
               rdq.size(), rspq.size());
    end
    for (int k = 0; k < 5 && k < rdq.size(); k++) begin
      ea = AW'(12'h100 + 16 * (k % N));
      n_cmp++;
      if (rdq[k].c != c0 + 1 + 2 * k || rdq[k].a !== ea) begin
        n_err++;
        $display("FAIL rr_rd[%0d]: cyc %0d addr %h want cyc %0d addr %h",
                 k, rdq[k].c - c0, rdq[k].a, 1 + 2 * k, ea);
      end
    end
    for (int k = 0; k < 5 && k < rspq.size(); k++) begin
      ev = N'(1) << (k % N);
      n_cmp++;
      if (rspq[k].c != c0 + 3 + 2 * k || rspq[k].v !== ev ||
          rspq[k].l !== 1'b1) begin
        n_err++;
        $display("FAIL rr_rsp[%0d]: cyc %0d vld %h last %b want %0d %h 1",
                 k, rspq[k].c - c0, rspq[k].v, rspq[k].l, 3 + 2 * k, ev);
      end
    end
  endtask

  task automatic test_single();
    int c0;
    logic [AW-1:0] ea;
    clr();
    set_req(0, 12'h010, 5'd3);
    bus.req_vld = 4'b0001;
    c0 = cyc;
    tick();
    bus.req_vld = '0;
    repeat (8) tick();
    n_cmp++;
    if (accq.size() != 1 || accq[0].c != c0 + 1 ||
        accq[0].v !== 4'b0001) begin
      n_err++;
      $display("FAIL single_acc: n %0d want 1 at cyc 1 val 0001",
               accq.size());
    end
    n_cmp++;
    if (rdq.size() != 4 || rspq.size() != 4) begin
      n_err++;
      $display("FAIL single_n: rd %0d rsp %0d want 4/4",
               rdq.size(), rspq.size());
    end
    for (int k = 0; k < 4 && k < rdq.size(); k++) begin
      ea = AW'(12'h010 + k);
      n_cmp++;
      if (rdq[k].c != c0 + 1 + k || rdq[k].a !== ea) begin
        n_err++;
        $display("FAIL single_rd[%0d]: cyc %0d addr %h want %0d %h",
                 k, rdq[k].c - c0, rdq[k].a, 1 + k, ea);
      end
    end
    for (int k = 0; k < 4 && k < rspq.size(); k++) begin
      ea = AW'(12'h010 + k);
      n_cmp++;
      if (rspq[k].c != c0 + 3 + k || rspq[k].v !== 4'b0001 ||
          rspq[k].l !== (k == 3) || rspq[k].d !== pat(ea)) begin
        n_err++;
        $display("FAIL single_rsp[%0d]: cyc %0d vld %h last %b data %h want %0d 0001 %b %h",
                 k, rspq[k].c - c0, rspq[k].v, rspq[k].l, rspq[k].d,
                 3 + k, k == 3, pat(ea));
      end
    end
    n_cmp++;
    if (busy_log[c0 + 6] !== 1'b1 || busy_log[c0 + 7] !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: got %b,%b want 1,0",
               busy_log[c0 + 6], busy_log[c0 + 7]);
    end
  endtask

  task automatic test_wrap();
    int c0;
    logic [AW-1:0] ea;
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 12'hFFE;
    exp_a[1] = 12'hFFF;
    exp_a[2] = 12'h000;
    clr();
    set_req(1, 12'hFFE, 5'd2);
    bus.req_vld = 4'b0010;
    c0 = cyc;
    tick();
    bus.req_vld = '0;
    repeat (7) tick();
    n_cmp++;
    if (rdq.size() != 3 || rspq.size() != 3) begin
      n_err++;
      $display("FAIL wrap_n: rd %0d rsp %0d want 3/3",
               rdq.size(), rspq.size());
    end
    for (int k = 0; k < 3 && k < rdq.size(); k++) begin
      ea = exp_a[k];
      n_cmp++;
      if (rdq[k].c != c0 + 1 + k || rdq[k].a !== ea) begin
        n_err++;
        $display("FAIL wrap_rd[%0d]: cyc %0d addr %h want %0d %h",
                 k, rdq[k].c - c0, rdq[k].a, 1 + k, ea);
      end
    end
    for (int k = 0; k < 3 && k < rspq.size(); k++) begin
      ea = exp_a[k];
      n_cmp++;
      if (rspq[k].c != c0 + 3 + k || rspq[k].v !== 4'b0010 ||
          rspq[k].l !== (k == 2) || rspq[k].d !== pat(ea)) begin
        n_err++;
        $display("FAIL wrap_rsp[%0d]: cyc %0d vld %h last %b data %h want %0d 0010 %b %h",
                 k, rspq[k].c - c0, rspq[k].v, rspq[k].l, rspq[k].d,
                 3 + k, k == 2, pat(ea));
      end
    end
  endtask

  task automatic test_pause();
    int c0;
    int ec;
    logic [AW-1:0] ea;
    clr();
    set_req(2, 12'h200, 5'd7);
    bus.req_vld = 4'b0100;
    c0 = cyc;
    tick();
    bus.req_vld = '0;
    tick();
    bus.pause = 1'b1;
    repeat (3) tick();
    bus.pause = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (rdq.size() != 8 || rspq.size() != 8) begin
      n_err++;
      $display("FAIL pause_n: rd %0d rsp %0d want 8/8",
               rdq.size(), rspq.size());
    end
    for (int k = 0; k < 8 && k < rdq.size() && k < rspq.size(); k++) begin
      ec = (k == 0) ? 1 : 4 + k;
      ea = AW'(12'h200 + k);
      n_cmp++;
      if (rdq[k].c != c0 + ec || rdq[k].a !== ea) begin
        n_err++;
        $display("FAIL pause_rd[%0d]: cyc %0d addr %h want %0d %h",
                 k, rdq[k].c - c0, rdq[k].a, ec, ea);
      end
      n_cmp++;
      if (rspq[k].c != c0 + ec + 2 || rspq[k].v !== 4'b0100 ||
          rspq[k].l !== (k == 7) || rspq[k].d !== pat(ea)) begin
        n_err++;
        $display("FAIL pause_rsp[%0d]: cyc %0d vld %h last %b want %0d 0100 %b",
                 k, rspq[k].c - c0, rspq[k].v, rspq[k].l, ec + 2, k == 7);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c1;
    clr();
    set_req(1, 12'h300, 5'd7);
    bus.req_vld = 4'b0010;
    tick();
    bus.req_vld = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdq.size() != 3 || rspq.size() != 1) begin
      n_err++;
      $display("FAIL rmid_pre: rd %0d rsp %0d want 3/1",
               rdq.size(), rspq.size());
    end
    n_cmp++;
    if (bus.req_acc !== '0 || bus.gb_rd_en !== 1'b0 ||
        bus.gb_rd_addr !== '0 || bus.rsp_vld !== '0 ||
        bus.rsp_last !== 1'b0 || bus.rsp_data !== '0 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_out: acc %h en %b addr %h vld %h last %b busy %b want all 0",
               bus.req_acc, bus.gb_rd_en, bus.gb_rd_addr, bus.rsp_vld,
               bus.rsp_last, bus.busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    clr();
    repeat (6) tick();
    n_cmp++;
    if (rdq.size() != 0 || rspq.size() != 0 || accq.size() != 0) begin
      n_err++;
      $display("FAIL rmid_quiet: rd %0d rsp %0d acc %0d want 0/0/0",
               rdq.size(), rspq.size(), accq.size());
    end
    for (int i = 0; i < N; i++) set_req(i, AW'(12'h400 + i), '0);
    bus.req_vld = 4'hF;
    c1 = cyc;
    tick();
    bus.req_vld = '0;
    repeat (5) tick();
    n_cmp++;
    if (accq.size() != 1 || accq[0].c != c1 + 1 ||
        accq[0].v !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_grant: n %0d val %h want 1 grant 0001",
               accq.size(), accq.size() > 0 ? accq[0].v : 4'h0);
    end
    n_cmp++;
    if (rdq.size() != 1 || rdq[0].a !== 12'h400) begin
      n_err++;
      $display("FAIL rmid_rd: n %0d want 1 at addr 400", rdq.size());
    end
  endtask

  initial begin
    bus.req_vld  = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    bus.pause    = 1'b0;
    test_reset();
    test_rr();
    test_single();
    test_wrap();
    test_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
